idex_stage: RTL and testbench
=============================

Name: idex_stage

Overview:
- ID/EX pipeline register plus operand forwarding for the 5-stage pipelined MIPS core.
- Captures decoded operands and control at the end of Decode.
- Resolves MEM/WB forwarding, selects register or immediate for operand B, and presents srca_e, srcb_e and alucontrol_e directly to the Execute-stage ALU.
- Also raises the load-use stall request back to the fetch/decode stages.

Parameters:
- WIDTH, 32, datapath width.
- REGW, 5, register-index width.
- CNTW, 16, width of the optional statistics counters.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- stall_e  in  1  hold the ID/EX contents
- flush_e  in  1  load a bubble into ID/EX
- valid_d  in  1  Decode holds a real instruction
- rd1_d, rd2_d  in  WIDTH  register-file read data
- signimm_d  in  WIDTH  sign-extended immediate
- rs_d, rt_d, rd_d  in  REGW  register indices
- regwrite_d, memtoreg_d, memwrite_d, alusrc_d, regdst_d  in  1  decoded control
- alucontrol_d  in  4  ALU control F
- aluout_m  in  WIDTH  MEM-stage result
- writereg_m  in  REGW  MEM-stage destination
- regwrite_m  in  1  MEM-stage write enable
- result_w  in  WIDTH  WB-stage result
- writereg_w  in  REGW  WB-stage destination
- regwrite_w  in  1  WB-stage write enable
- srca_e, srcb_e  out  WIDTH  ALU operands A and B
- alucontrol_e  out  4  ALU control F
- writedata_e  out  WIDTH  forwarded rt value, used as store data
- writereg_e  out  REGW  destination: rd_e if regdst_e, else rt_e
- regwrite_e, memtoreg_e, memwrite_e, valid_e  out  1  registered control
- lwstall  out  1  load-use hazard request to Fetch/Decode

Behaviour:
- Update priority on each rising edge: reset > flush_e > stall_e > load.
- reset or flush_e:
  - valid, regwrite, memtoreg, memwrite, alusrc, regdst clear to 0.
  - alucontrol clears to 4'b0000; data and index registers clear to 0.
  - Consequence: srca_e = srcb_e = writedata_e = 0, writereg_e = 0, lwstall = 0.
- stall_e (without flush_e): every register holds its value.
- Otherwise: all *_d inputs are registered. Latency is 1 cycle from Decode to Execute.
- Forwarding for operand A is combinational in the same cycle, with this priority:
  - If regwrite_m and writereg_m != 0 and writereg_m == rs_e: select aluout_m.
  - Else if regwrite_w and writereg_w != 0 and writereg_w == rs_e: select result_w.
  - Else: select rd1_e.
  - MEM always beats WB. Register 0 is never forwarded.
- Forwarding for rt is identical, using rd2_e, and drives writedata_e.
- srcb_e = signimm_e if alusrc_e, else the forwarded rt value.
- lwstall = valid_e & memtoreg_e & (rt_e != 0) & (rt_e == rs_d | rt_e == rt_d).
  - The external hazard unit uses it to stall F/D and assert flush_e. The resulting bubble is inserted next cycle.
- Bubble and flush: a bubble has every write and memory enable at 0, so it produces no architectural side effects.
- Widths: no arithmetic in this block. All comparisons are on full REGW bits.

Optional Feature:
- Macro: IDEX_FWD_STATS_EN.
- When defined, add output ports fwd_m_cnt, fwd_w_cnt and bubble_cnt (each CNTW bits), all reset to 0:
  - fwd_m_cnt increments once per cycle in which valid_e is high and either operand selects aluout_m.
  - fwd_w_cnt increments likewise when either operand selects result_w and neither selects aluout_m.
  - bubble_cnt increments on each edge where flush_e loads a bubble, but not on reset.
  - All counters saturate at all-ones and do not wrap.
- When undefined: the ports and the logic are absent, and behaviour is otherwise identical.

Decomposition:
- Package mips_pkg holds:
  - ALU control constants: AND 4'b0000, OR 4'b0001, ADD 4'b0010, SUB 4'b1010, SLT 4'b1011.
  - Forward-select enum: FWD_RF, FWD_WB, FWD_MEM.
  - The REGW constant.
- Sub-module fwd_mux, instantiated twice (rs and rt): takes the register index, the three candidate values and the MEM/WB tags, and returns the selected value plus the select code.

Test Plan:
- Pulse reset with arbitrary inputs → next cycle all outputs are 0, valid_e = 0, lwstall = 0.
- Plain load: rd1_d = 32'h11, rd2_d = 32'h22, alusrc_d = 0, alucontrol_d = 4'b0010, no forwarding → next cycle srca_e = 32'h11, srcb_e = 32'h22, alucontrol_e = 4'b0010.
- Priority: rs_e = 5, regwrite_m = 1, writereg_m = 5, aluout_m = 32'hAAAA, and WB also targets 5 with result_w = 32'hBBBB → srca_e = 32'hAAAA. Drop regwrite_m → srca_e = 32'hBBBB.
- Register 0: rs_e = 0, writereg_m = 0, regwrite_m = 1, aluout_m = 32'hFFFF → srca_e = rd1_e. Separately, alusrc_e = 1, signimm_e = 32'hFFFF_FFFC → srcb_e = 32'hFFFF_FFFC while writedata_e still shows the forwarded rt.
- Load-use: EX holds memtoreg_e = 1, rt_e = 8, and rs_d = 8 → lwstall = 1. After flush_e: valid_e = 0, regwrite_e = 0, lwstall = 0. The same case with rt_e = 0 → lwstall = 0.
- flush_e and stall_e asserted together → bubble is loaded. stall_e alone for 3 cycles with changing *_d → outputs frozen. With IDEX_FWD_STATS_EN defined, bubble_cnt = 1 after this sequence.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS pipeline slice.
package mips_pkg;

   localparam int REGW = 5;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b1010;
   localparam logic [3:0] ALU_SLT = 4'b1011;

   typedef enum logic [1:0] {
      FWD_RF  = 2'd0,
      FWD_WB  = 2'd1,
      FWD_MEM = 2'd2
   } fwd_sel_t;

endpackage

// File: rtl/idex_stage_fwd_mux.sv
// Operand forwarding mux: MEM result beats WB result beats register file; r0 never forwarded.
import mips_pkg::*;

module fwd_mux #(
   parameter int WIDTH = 32,
   parameter int RW    = mips_pkg::REGW
) (
   input  logic [RW-1:0]    idx,
   input  logic [WIDTH-1:0] rf_val,
   input  logic [WIDTH-1:0] m_val,
   input  logic [WIDTH-1:0] w_val,
   input  logic [RW-1:0]    writereg_m,
   input  logic             regwrite_m,
   input  logic [RW-1:0]    writereg_w,
   input  logic             regwrite_w,
   output logic [WIDTH-1:0] val,
   output fwd_sel_t         sel
);

   always_comb begin
      sel = FWD_RF;
      val = rf_val;
      if (regwrite_m && (writereg_m != '0) && (writereg_m == idx)) begin
         sel = FWD_MEM;
         val = m_val;
      end else if (regwrite_w && (writereg_w != '0) && (writereg_w == idx)) begin
         sel = FWD_WB;
         val = w_val;
      end
   end

endmodule

// File: rtl/idex_stage.sv
// ID/EX pipeline register with MEM/WB forwarding and load-use stall detection.
// Optional forwarding/bubble statistics counters: define IDEX_FWD_STATS_EN.
import mips_pkg::*;

module idex_stage #(
   parameter int WIDTH = 32,
   parameter int REGW  = mips_pkg::REGW,
   parameter int CNTW  = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall_e,
   input  logic             flush_e,
   input  logic             valid_d,
   input  logic [WIDTH-1:0] rd1_d,
   input  logic [WIDTH-1:0] rd2_d,
   input  logic [WIDTH-1:0] signimm_d,
   input  logic [REGW-1:0]  rs_d,
   input  logic [REGW-1:0]  rt_d,
   input  logic [REGW-1:0]  rd_d,
   input  logic             regwrite_d,
   input  logic             memtoreg_d,
   input  logic             memwrite_d,
   input  logic             alusrc_d,
   input  logic             regdst_d,
   input  logic [3:0]       alucontrol_d,
   input  logic [WIDTH-1:0] aluout_m,
   input  logic [REGW-1:0]  writereg_m,
   input  logic             regwrite_m,
   input  logic [WIDTH-1:0] result_w,
   input  logic [REGW-1:0]  writereg_w,
   input  logic             regwrite_w,
   output logic [WIDTH-1:0] srca_e,
   output logic [WIDTH-1:0] srcb_e,
   output logic [3:0]       alucontrol_e,
   output logic [WIDTH-1:0] writedata_e,
   output logic [REGW-1:0]  writereg_e,
   output logic             regwrite_e,
   output logic             memtoreg_e,
   output logic             memwrite_e,
   output logic             valid_e,
   output logic             lwstall
`ifdef IDEX_FWD_STATS_EN
  ,output logic [CNTW-1:0]  fwd_m_cnt,
   output logic [CNTW-1:0]  fwd_w_cnt,
   output logic [CNTW-1:0]  bubble_cnt
`endif
);

   logic [WIDTH-1:0] rd1_e, rd2_e, signimm_e;
   logic [REGW-1:0]  rs_e, rt_e, rd_e;
   logic             alusrc_e, regdst_e;
   fwd_sel_t         sel_a, sel_b;

   // reset and flush both load a bubble; stall holds everything
   always_ff @(posedge clk) begin
      if (reset || flush_e) begin
         valid_e      <= 1'b0;
         regwrite_e   <= 1'b0;
         memtoreg_e   <= 1'b0;
         memwrite_e   <= 1'b0;
         alusrc_e     <= 1'b0;
         regdst_e     <= 1'b0;
         alucontrol_e <= '0;
         rd1_e        <= '0;
         rd2_e        <= '0;
         signimm_e    <= '0;
         rs_e         <= '0;
         rt_e         <= '0;
         rd_e         <= '0;
      end else if (!stall_e) begin
         valid_e      <= valid_d;
         regwrite_e   <= regwrite_d;
         memtoreg_e   <= memtoreg_d;
         memwrite_e   <= memwrite_d;
         alusrc_e     <= alusrc_d;
         regdst_e     <= regdst_d;
         alucontrol_e <= alucontrol_d;
         rd1_e        <= rd1_d;
         rd2_e        <= rd2_d;
         signimm_e    <= signimm_d;
         rs_e         <= rs_d;
         rt_e         <= rt_d;
         rd_e         <= rd_d;
      end
   end

   fwd_mux #(.WIDTH(WIDTH), .RW(REGW)) u_fwd_a (
      .idx        (rs_e),
      .rf_val     (rd1_e),
      .m_val      (aluout_m),
      .w_val      (result_w),
      .writereg_m (writereg_m),
      .regwrite_m (regwrite_m),
      .writereg_w (writereg_w),
      .regwrite_w (regwrite_w),
      .val        (srca_e),
      .sel        (sel_a)
   );

   fwd_mux #(.WIDTH(WIDTH), .RW(REGW)) u_fwd_b (
      .idx        (rt_e),
      .rf_val     (rd2_e),
      .m_val      (aluout_m),
      .w_val      (result_w),
      .writereg_m (writereg_m),
      .regwrite_m (regwrite_m),
      .writereg_w (writereg_w),
      .regwrite_w (regwrite_w),
      .val        (writedata_e),
      .sel        (sel_b)
   );

   assign srcb_e     = alusrc_e ? signimm_e : writedata_e;
   assign writereg_e = regdst_e ? rd_e : rt_e;
   assign lwstall    = valid_e & memtoreg_e & (rt_e != '0) &
                       ((rt_e == rs_d) | (rt_e == rt_d));

`ifdef IDEX_FWD_STATS_EN
   logic any_m, any_w;
   assign any_m = (sel_a == FWD_MEM) || (sel_b == FWD_MEM);
   assign any_w = (sel_a == FWD_WB)  || (sel_b == FWD_WB);

   always_ff @(posedge clk) begin
      if (reset) begin
         fwd_m_cnt  <= '0;
         fwd_w_cnt  <= '0;
         bubble_cnt <= '0;
      end else begin
         if (valid_e && any_m && (fwd_m_cnt != '1))
            fwd_m_cnt <= fwd_m_cnt + 1'b1;
         if (valid_e && any_w && !any_m && (fwd_w_cnt != '1))
            fwd_w_cnt <= fwd_w_cnt + 1'b1;
         if (flush_e && (bubble_cnt != '1))
            bubble_cnt <= bubble_cnt + 1'b1;
      end
   end
`else
   logic unused_sel;
   assign unused_sel = ^{sel_a, sel_b};
`endif

endmodule

// File: tb/tb_idex_stage.sv
// Directed self-checking bench for idex_stage (stats checks when IDEX_FWD_STATS_EN is defined).
module tb_idex_stage;

   logic        clk = 1'b0;
   logic        reset, stall_e, flush_e, valid_d;
   logic [31:0] rd1_d, rd2_d, signimm_d;
   logic [4:0]  rs_d, rt_d, rd_d;
   logic        regwrite_d, memtoreg_d, memwrite_d, alusrc_d, regdst_d;
   logic [3:0]  alucontrol_d;
   logic [31:0] aluout_m, result_w;
   logic [4:0]  writereg_m, writereg_w;
   logic        regwrite_m, regwrite_w;
   logic [31:0] srca_e, srcb_e, writedata_e;
   logic [3:0]  alucontrol_e;
   logic [4:0]  writereg_e;
   logic        regwrite_e, memtoreg_e, memwrite_e, valid_e, lwstall;
`ifdef IDEX_FWD_STATS_EN
   logic [15:0] fwd_m_cnt, fwd_w_cnt, bubble_cnt;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   idex_stage #(.WIDTH(32), .REGW(5), .CNTW(16)) dut (
      .clk(clk), .reset(reset), .stall_e(stall_e), .flush_e(flush_e), .valid_d(valid_d),
      .rd1_d(rd1_d), .rd2_d(rd2_d), .signimm_d(signimm_d),
      .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d),
      .regwrite_d(regwrite_d), .memtoreg_d(memtoreg_d), .memwrite_d(memwrite_d),
      .alusrc_d(alusrc_d), .regdst_d(regdst_d), .alucontrol_d(alucontrol_d),
      .aluout_m(aluout_m), .writereg_m(writereg_m), .regwrite_m(regwrite_m),
      .result_w(result_w), .writereg_w(writereg_w), .regwrite_w(regwrite_w),
      .srca_e(srca_e), .srcb_e(srcb_e), .alucontrol_e(alucontrol_e),
      .writedata_e(writedata_e), .writereg_e(writereg_e),
      .regwrite_e(regwrite_e), .memtoreg_e(memtoreg_e), .memwrite_e(memwrite_e),
      .valid_e(valid_e), .lwstall(lwstall)
`ifdef IDEX_FWD_STATS_EN
     ,.fwd_m_cnt(fwd_m_cnt), .fwd_w_cnt(fwd_w_cnt), .bubble_cnt(bubble_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic no_fwd();
      regwrite_m = 1'b0; writereg_m = '0; aluout_m = '0;
      regwrite_w = 1'b0; writereg_w = '0; result_w = '0;
   endtask

   task automatic dec(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                      input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] imm,
                      input logic rw, input logic mtr, input logic asrc, input logic rdst,
                      input logic [3:0] ac);
      valid_d = 1'b1; rs_d = rs; rt_d = rt; rd_d = rd;
      rd1_d = r1; rd2_d = r2; signimm_d = imm;
      regwrite_d = rw; memtoreg_d = mtr; memwrite_d = 1'b0;
      alusrc_d = asrc; regdst_d = rdst; alucontrol_d = ac;
   endtask

   initial begin
      // reset with arbitrary inputs
      reset = 1'b1; stall_e = 1'b0; flush_e = 1'b0;
      dec(5'd3, 5'd4, 5'd9, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h1234_5678, 1'b1, 1'b1, 1'b0, 1'b1, 4'b1011);
      memwrite_d = 1'b1;
      regwrite_m = 1'b1; writereg_m = 5'd3; aluout_m = 32'h5555;
      regwrite_w = 1'b1; writereg_w = 5'd4; result_w = 32'h6666;
      step();
      chk("rst_srca", srca_e, 32'h0);
      chk("rst_srcb", srcb_e, 32'h0);
      chk("rst_wdata", writedata_e, 32'h0);
      chk("rst_wreg", {27'b0, writereg_e}, 32'h0);
      chk("rst_aluc", {28'b0, alucontrol_e}, 32'h0);
      chk("rst_ctrl", {28'b0, valid_e, regwrite_e, memtoreg_e, memwrite_e}, 32'h0);
      chk("rst_lwstall", {31'b0, lwstall}, 32'h0);
`ifdef IDEX_FWD_STATS_EN
      chk("rst_bubble_cnt", {16'b0, bubble_cnt}, 32'h0);
`endif
      reset = 1'b0;
      no_fwd();

      // plain load
      dec(5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0010);
      step();
      chk("plain_srca", srca_e, 32'h11);
      chk("plain_srcb", srcb_e, 32'h22);
      chk("plain_aluc", {28'b0, alucontrol_e}, 32'h2);
      chk("plain_wreg", {27'b0, writereg_e}, 32'd3);
      chk("plain_ctrl", {28'b0, valid_e, regwrite_e, memtoreg_e, memwrite_e}, 32'b1100);
      chk("plain_wdata", writedata_e, 32'h22);

      // MEM vs WB priority
      dec(5'd5, 5'd6, 5'd7, 32'h55, 32'h66, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1010);
      step();
      chk("prio_wreg_rt", {27'b0, writereg_e}, 32'd6);
      regwrite_m = 1'b1; writereg_m = 5'd5; aluout_m = 32'hAAAA;
      regwrite_w = 1'b1; writereg_w = 5'd5; result_w = 32'hBBBB;
      #1;
      chk("prio_mem", srca_e, 32'hAAAA);
      chk("prio_rt_untouched", writedata_e, 32'h66);
      regwrite_m = 1'b0;
      #1;
      chk("prio_wb", srca_e, 32'hBBBB);
      regwrite_w = 1'b0;
      #1;
      chk("prio_rf", srca_e, 32'h55);
      regwrite_w = 1'b1; writereg_w = 5'd6;
      #1;
      chk("rt_wb_wdata", writedata_e, 32'hBBBB);
      chk("rt_wb_srcb", srcb_e, 32'hBBBB);
      regwrite_m = 1'b1; writereg_m = 5'd6;
      #1;
      chk("rt_mem_wdata", writedata_e, 32'hAAAA);
      chk("rt_mem_srca", srca_e, 32'h55);
      no_fwd();

      // register 0 and immediate operand
      dec(5'd0, 5'd7, 5'd0, 32'h10, 32'h77, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0010);
      step();
      regwrite_m = 1'b1; writereg_m = 5'd0; aluout_m = 32'hFFFF;
      regwrite_w = 1'b1; writereg_w = 5'd7; result_w = 32'h1234;
      #1;
      chk("r0_srca", srca_e, 32'h10);
      chk("imm_srcb", srcb_e, 32'hFFFF_FFFC);
      chk("imm_wdata_fwd", writedata_e, 32'h1234);
      no_fwd();

      // load-use
      dec(5'd2, 5'd8, 5'd0, 32'h1, 32'h2, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0010);
      step();
      rs_d = 5'd8; rt_d = 5'd3;
      #1;
      chk("lu_rs", {31'b0, lwstall}, 32'h1);
      rs_d = 5'd9; rt_d = 5'd8;
      #1;
      chk("lu_rt", {31'b0, lwstall}, 32'h1);
      rt_d = 5'd9;
      #1;
      chk("lu_none", {31'b0, lwstall}, 32'h0);
      rs_d = 5'd8;
      flush_e = 1'b1;
      step();
      flush_e = 1'b0;
      chk("lu_flush_valid", {31'b0, valid_e}, 32'h0);
      chk("lu_flush_rw", {31'b0, regwrite_e}, 32'h0);
      chk("lu_flush_lwstall", {31'b0, lwstall}, 32'h0);
      dec(5'd2, 5'd0, 5'd0, 32'h1, 32'h2, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0010);
      step();
      rs_d = 5'd0; rt_d = 5'd0;
      #1;
      chk("lu_r0", {31'b0, lwstall}, 32'h0);

      // fresh reset so bubble_cnt reflects only this section
      reset = 1'b1;
      step();
      reset = 1'b0;
      dec(5'd4, 5'd1, 5'd0, 32'h99, 32'h9, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0001);
      step();
      chk("pre_flush_valid", {31'b0, valid_e}, 32'h1);
      stall_e = 1'b1; flush_e = 1'b1;
      step();
      flush_e = 1'b0; stall_e = 1'b0;
      chk("flush_stall_valid", {31'b0, valid_e}, 32'h0);
      chk("flush_stall_srca", srca_e, 32'h0);
      chk("flush_stall_aluc", {28'b0, alucontrol_e}, 32'h0);
      dec(5'd10, 5'd11, 5'd12, 32'h123, 32'h456, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1011);
      step();
      stall_e = 1'b1;
      for (int i = 0; i < 3; i++) begin
         dec(5'(13 + i), 5'(20 + i), 5'(25 + i), 32'h1000 + 32'(i), 32'h2000 + 32'(i),
             32'h7, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000);
         step();
         chk("stall_srca", srca_e, 32'h123);
         chk("stall_srcb", srcb_e, 32'h456);
         chk("stall_aluc", {28'b0, alucontrol_e}, 32'hB);
         chk("stall_wreg", {27'b0, writereg_e}, 32'd12);
         chk("stall_ctrl", {28'b0, valid_e, regwrite_e, memtoreg_e, memwrite_e}, 32'b1100);
      end
      stall_e = 1'b0;
`ifdef IDEX_FWD_STATS_EN
      chk("bubble_cnt", {16'b0, bubble_cnt}, 32'd1);
      chk("fwd_m_cnt", {16'b0, fwd_m_cnt}, 32'd0);
      chk("fwd_w_cnt", {16'b0, fwd_w_cnt}, 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
